// File: rtl/awg_pkg.sv
// Shared definitions for the AWG command decoder and waveform generator:
// frame sync byte, command codes, waveform and decoder-state enums.
package awg_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [7:0] CMD_WAVE  = 8'h01;
    localparam logic [7:0] CMD_FREQ  = 8'h02;
    localparam logic [7:0] CMD_AMP   = 8'h03;
    localparam logic [7:0] CMD_OFS   = 8'h04;
    localparam logic [7:0] CMD_APPLY = 8'h05;

    typedef enum logic [1:0] {
        WAVE_SINE     = 2'd0,
        WAVE_SQUARE   = 2'd1,
        WAVE_TRIANGLE = 2'd2,
        WAVE_SAWTOOTH = 2'd3
    } wave_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_DHI  = 3'd2,
        ST_DLO  = 3'd3,
        ST_CSUM = 3'd4
    } state_t;

    // Known command whose payload fits the target register.
    function automatic logic cmd_data_ok(input logic [7:0] cmd, input logic [15:0] data);
        logic ok;
        ok = 1'b0;
        case (cmd)
            CMD_WAVE:          ok = (data[15:2] == 14'd0);
            CMD_FREQ:          ok = 1'b1;
            CMD_AMP, CMD_OFS:  ok = (data[15:10] == 6'd0);
            CMD_APPLY:         ok = 1'b1;
            default:           ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/awg_byte_timeout.sv
// Inter-byte idle counter: clears on every byte, counts while a frame is open,
// saturates at TIMEOUT_CYCLES. A byte on the terminal-count cycle suppresses expiry.
module awg_byte_timeout #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic terminal,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || !enable) begin
            count <= '0;
        end else if (count != CNT_MAX) begin
            count <= count + CNT_W'(1);
        end
    end

    assign terminal = enable && (count == CNT_MAX);
    assign expired  = terminal && !clear;

endmodule

// File: rtl/awg_cmd_decoder.sv
// Frames 5-byte UART commands (A5 CMD DHI DLO CSUM), validates them at the
// checksum byte, writes shadow registers and commits them atomically on apply.
module awg_cmd_decoder
    import awg_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter logic [1:0]  RST_WAVE       = 2'd0,
    parameter logic [15:0] RST_FREQ       = 16'd1000,
    parameter logic [9:0]  RST_AMP        = 10'd511,
    parameter logic [9:0]  RST_OFS        = 10'd512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  uart_data,
    input  logic        data_valid,
    output logic [1:0]  waveform_type,
    output logic [15:0] frequency,
    output logic [9:0]  amplitude,
    output logic [9:0]  dc_offset,
    output logic        cfg_update,
    output logic        frame_ok,
    output logic        frame_err
);

    state_t      state, state_next;
    logic [7:0]  cmd_byte;
    logic [7:0]  dhi_byte;
    logic [7:0]  dlo_byte;
    logic [15:0] frame_data;
    logic        csum_match;
    logic        frame_good;

    wave_t       shadow_wave;
    logic [15:0] shadow_freq;
    logic [9:0]  shadow_amp;
    logic [9:0]  shadow_ofs;

    logic        tmo_terminal;
    logic        tmo_expired;

    logic        accept;
    logic        reject;
    logic        commit;

    awg_byte_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (data_valid),
        .enable   (state != ST_IDLE),
        .terminal (tmo_terminal),
        .expired  (tmo_expired)
    );

    assign frame_data = {dhi_byte, dlo_byte};
    assign csum_match = (uart_data == (cmd_byte ^ dhi_byte ^ dlo_byte));
    assign frame_good = csum_match && cmd_data_ok(cmd_byte, frame_data);

    // Next state and the single-cycle decisions taken on this edge.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        reject     = 1'b0;
        commit     = 1'b0;
        if (tmo_expired) begin
            state_next = ST_IDLE;
            reject     = 1'b1;
        end else if (data_valid) begin
            case (state)
                ST_IDLE: if (uart_data == SYNC_BYTE) state_next = ST_CMD;
                ST_CMD:  state_next = ST_DHI;
                ST_DHI:  state_next = ST_DLO;
                ST_DLO:  state_next = ST_CSUM;
                ST_CSUM: begin
                    state_next = ST_IDLE;
                    if (frame_good) begin
                        accept = 1'b1;
                        commit = (cmd_byte == CMD_APPLY);
                    end else begin
                        reject = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame byte capture; contents are only meaningful once the frame reaches CSUM.
    always_ff @(posedge clk) begin
        if (data_valid) begin
            case (state)
                ST_CMD:  cmd_byte <= uart_data;
                ST_DHI:  dhi_byte <= uart_data;
                ST_DLO:  dlo_byte <= uart_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_wave <= wave_t'(RST_WAVE);
            shadow_freq <= RST_FREQ;
            shadow_amp  <= RST_AMP;
            shadow_ofs  <= RST_OFS;
        end else if (accept) begin
            case (cmd_byte)
                CMD_WAVE: shadow_wave <= wave_t'(frame_data[1:0]);
                CMD_FREQ: shadow_freq <= frame_data;
                CMD_AMP:  shadow_amp  <= frame_data[9:0];
                CMD_OFS:  shadow_ofs  <= frame_data[9:0];
                default:  ;
            endcase
        end
    end

    // Active outputs move only together, on an accepted apply.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            waveform_type <= RST_WAVE;
            frequency     <= RST_FREQ;
            amplitude     <= RST_AMP;
            dc_offset     <= RST_OFS;
        end else if (commit) begin
            waveform_type <= shadow_wave;
            frequency     <= shadow_freq;
            amplitude     <= shadow_amp;
            dc_offset     <= shadow_ofs;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;
            cfg_update <= 1'b0;
        end else begin
            frame_ok   <= accept;
            frame_err  <= reject;
            cfg_update <= commit;
        end
    end

endmodule
